id_ex_stage: RTL and testbench

//  ID/EX pipeline register plus operand-forwarding and load-use hazard logic.

---
 rtl/id_ex_stage.sv | 139 +++++++++++++
 tb/tb_id_ex_stage.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use hazard detection.
// Define FORWARDING_EN for the forwarding build; otherwise RAW hazards stall until writeback.
module id_ex_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_AW     = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_AW-1:0]     id_rs1,
    input  logic [REG_AW-1:0]     id_rs2,
    input  logic [REG_AW-1:0]     id_rd,
    input  logic [DATA_WIDTH-1:0] id_rd1,
    input  logic [DATA_WIDTH-1:0] id_rd2,
    input  logic [DATA_WIDTH-1:0] id_imm,
    input  logic                  id_alusrc,
    input  logic [2:0]            id_aluctrl,
    input  logic                  id_regwrite,
    input  logic                  id_memread,
    input  logic                  flush,
    input  logic [REG_AW-1:0]     mem_rd,
    input  logic                  mem_regwrite,
    input  logic [DATA_WIDTH-1:0] mem_result,
    input  logic [REG_AW-1:0]     wb_rd,
    input  logic                  wb_regwrite,
    input  logic [DATA_WIDTH-1:0] wb_result,
    output logic                  stall_id,
    output logic                  ex_valid,
    output logic [2:0]            ALUctrl,
    output logic [DATA_WIDTH-1:0] ALUop1,
    output logic [DATA_WIDTH-1:0] ALUop2,
    output logic [DATA_WIDTH-1:0] ex_store_data,
    output logic [REG_AW-1:0]     ex_rd,
    output logic                  ex_regwrite,
    output logic                  ex_memread
);

    logic [REG_AW-1:0]     rs1_q, rs2_q, rd_q;
    logic [DATA_WIDTH-1:0] rd1_q, rd2_q, imm_q;
    logic                  alusrc_q, regwrite_q, memread_q;
    logic [2:0]            aluctrl_q;

    logic load_use, hz, bubble;
    logic [DATA_WIDTH-1:0] fwd_rs1, fwd_rs2;

    // True when the ID instruction reads a non-zero register r.
    function automatic logic id_reads(input logic v, input logic [REG_AW-1:0] s1,
                                      input logic [REG_AW-1:0] s2, input logic [REG_AW-1:0] r);
        return v && (r != '0) && ((s1 == r) || (s2 == r));
    endfunction

    // The rs2 compare ignores id_alusrc on purpose: a spurious stall is cheaper than a missed one.
    assign load_use = ex_valid && memread_q && id_reads(id_valid, id_rs1, id_rs2, rd_q);

`ifdef FORWARDING_EN
    function automatic logic [DATA_WIDTH-1:0] fwd(input logic [REG_AW-1:0] rs,
                                                  input logic [DATA_WIDTH-1:0] latched,
                                                  input logic [REG_AW-1:0] m_rd, input logic m_rw,
                                                  input logic [DATA_WIDTH-1:0] m_res,
                                                  input logic [REG_AW-1:0] w_rd, input logic w_rw,
                                                  input logic [DATA_WIDTH-1:0] w_res);
        if (m_rw && (m_rd != '0) && (m_rd == rs))
            return m_res;
        else if (w_rw && (w_rd != '0) && (w_rd == rs))
            return w_res;
        else
            return latched;
    endfunction

    assign hz      = load_use;
    assign fwd_rs1 = fwd(rs1_q, rd1_q, mem_rd, mem_regwrite, mem_result, wb_rd, wb_regwrite, wb_result);
    assign fwd_rs2 = fwd(rs2_q, rd2_q, mem_rd, mem_regwrite, mem_result, wb_rd, wb_regwrite, wb_result);
`else
    logic raw_ex, raw_mem;
    logic unused_nofwd;

    // Without bypassing, any producer still in EX or MEM must retire before ID may issue.
    assign raw_ex  = ex_valid && regwrite_q && id_reads(id_valid, id_rs1, id_rs2, rd_q);
    assign raw_mem = mem_regwrite && id_reads(id_valid, id_rs1, id_rs2, mem_rd);
    assign hz      = load_use || raw_ex || raw_mem;
    assign fwd_rs1 = rd1_q;
    assign fwd_rs2 = rd2_q;
    assign unused_nofwd = ^{mem_result, wb_rd, wb_regwrite, wb_result, rs1_q, rs2_q};
`endif

    // Handshake: stall_id holds PC and IF/ID; while it is high the ID instruction is not
    // consumed and a bubble enters EX. flush squashes ID outright, so it never stalls.
    assign stall_id = hz && !flush;
    assign bubble   = flush || hz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid   <= 1'b0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            rd1_q      <= '0;
            rd2_q      <= '0;
            imm_q      <= '0;
            alusrc_q   <= 1'b0;
            aluctrl_q  <= 3'b000;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
        end else if (bubble) begin
            ex_valid   <= 1'b0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            rd1_q      <= '0;
            rd2_q      <= '0;
            imm_q      <= '0;
            alusrc_q   <= 1'b0;
            aluctrl_q  <= 3'b000;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
        end else begin
            ex_valid   <= id_valid;
            rs1_q      <= id_rs1;
            rs2_q      <= id_rs2;
            rd_q       <= id_rd;
            rd1_q      <= id_rd1;
            rd2_q      <= id_rd2;
            imm_q      <= id_imm;
            alusrc_q   <= id_alusrc;
            aluctrl_q  <= id_aluctrl;
            regwrite_q <= id_regwrite;
            memread_q  <= id_memread;
        end
    end

    assign ALUctrl       = aluctrl_q;
    assign ALUop1        = fwd_rs1;
    assign ALUop2        = alusrc_q ? imm_q : fwd_rs2;
    assign ex_store_data = fwd_rs2;
    assign ex_rd         = rd_q;
    assign ex_regwrite   = regwrite_q && ex_valid;
    assign ex_memread    = memread_q && ex_valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed scoreboard bench for id_ex_stage; expectations follow the FORWARDING_EN setting.
module tb_id_ex_stage;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int EW = 3 + 3*DW + AW + 2;

    logic          clk, rst_n;
    logic          id_valid, id_alusrc, id_regwrite, id_memread, flush;
    logic [AW-1:0] id_rs1, id_rs2, id_rd, mem_rd, wb_rd;
    logic [DW-1:0] id_rd1, id_rd2, id_imm, mem_result, wb_result;
    logic [2:0]    id_aluctrl;
    logic          mem_regwrite, wb_regwrite;
    logic          stall_id, ex_valid, ex_regwrite, ex_memread;
    logic [2:0]    ALUctrl;
    logic [DW-1:0] ALUop1, ALUop2, ex_store_data;
    logic [AW-1:0] ex_rd;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_alusrc(id_alusrc), .id_aluctrl(id_aluctrl), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .flush(flush), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
        .mem_result(mem_result), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
        .wb_result(wb_result), .stall_id(stall_id), .ex_valid(ex_valid), .ALUctrl(ALUctrl),
        .ALUop1(ALUop1), .ALUop2(ALUop2), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [EW-1:0] exp_q[$];

    // driver tasks
    task automatic set_id(input logic v, input logic [AW-1:0] rs1, rs2, rd,
                          input logic [DW-1:0] rd1, rd2, imm, input logic src,
                          input logic [2:0] ctrl, input logic rw, mr);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_rd1 = rd1; id_rd2 = rd2; id_imm = imm; id_alusrc = src;
        id_aluctrl = ctrl; id_regwrite = rw; id_memread = mr;
    endtask

    task automatic set_fwd(input logic [AW-1:0] mrd, input logic mrw, input logic [DW-1:0] mres,
                           input logic [AW-1:0] wrd, input logic wrw, input logic [DW-1:0] wres);
        mem_rd = mrd; mem_regwrite = mrw; mem_result = mres;
        wb_rd = wrd; wb_regwrite = wrw; wb_result = wres;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_stall(input string name, input logic exp);
        #1;
        check(name, {31'd0, stall_id}, {31'd0, exp});
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ex_valid"}, {31'd0, ex_valid}, 0);
        check({tag, "_stall_id"}, {31'd0, stall_id}, 0);
        check({tag, "_aluctrl"}, {29'd0, ALUctrl}, 0);
        check({tag, "_aluop1"}, ALUop1, 0);
        check({tag, "_aluop2"}, ALUop2, 0);
        check({tag, "_store"}, ex_store_data, 0);
        check({tag, "_ex_rd"}, {27'd0, ex_rd}, 0);
        check({tag, "_regwrite"}, {31'd0, ex_regwrite}, 0);
        check({tag, "_memread"}, {31'd0, ex_memread}, 0);
    endtask

    task automatic check_bubble(input string tag);
        check({tag, "_ex_valid"}, {31'd0, ex_valid}, 0);
        check({tag, "_regwrite"}, {31'd0, ex_regwrite}, 0);
        check({tag, "_memread"}, {31'd0, ex_memread}, 0);
    endtask

    task automatic push_exp(input logic [2:0] c, input logic [DW-1:0] o1, o2, sd,
                            input logic [AW-1:0] rd, input logic rw, mr);
        exp_q.push_back({c, o1, o2, sd, rd, rw, mr});
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [EW-1:0] e, got;
        if (rst_n && ex_valid) begin
            n_checks++;
            got = {ALUctrl, ALUop1, ALUop2, ex_store_data, ex_rd, ex_regwrite, ex_memread};
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL ex_out: unexpected instruction, got %0h expected none", got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL ex_out: got ctrl=%0h op1=%0h op2=%0h sd=%0h rd=%0h rw=%0b mr=%0b expected %0h",
                             ALUctrl, ALUop1, ALUop2, ex_store_data, ex_rd, ex_regwrite, ex_memread, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        flush = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0);
        set_fwd(0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1 check_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // ADD 5 + 7
        set_id(1, 1, 2, 3, 32'd5, 32'd7, 0, 0, 3'b000, 1, 0);
        check_stall("stall_add", 0);
        push_exp(3'b000, 32'd5, 32'd7, 32'd7, 3, 1, 0);
        tick();

        // SUB with immediate; rs1 forwarded in its EX cycle (MEM beats WB)
        set_id(1, 5, 6, 7, 32'h100, 32'h200, 32'h10, 1, 3'b001, 1, 0);
        check_stall("stall_sub", 0);
`ifdef FORWARDING_EN
        push_exp(3'b001, 32'hAA, 32'h10, 32'h200, 7, 1, 0);
`else
        push_exp(3'b001, 32'h100, 32'h10, 32'h200, 7, 1, 0);
`endif
        tick();

        // OR reading x0 and rs2=8; x0 must not forward, rs2 from WB
        set_fwd(5, 1, 32'hAA, 5, 1, 32'hBB);
        set_id(1, 0, 8, 9, 32'h33, 32'h44, 0, 0, 3'b011, 1, 0);
        check_stall("stall_or", 0);
`ifdef FORWARDING_EN
        push_exp(3'b011, 32'h33, 32'hBB, 32'hBB, 9, 1, 0);
`else
        push_exp(3'b011, 32'h33, 32'h44, 32'h44, 9, 1, 0);
`endif
        tick();

        // load rd=4
        set_fwd(0, 1, 32'hAA, 8, 1, 32'hBB);
        set_id(1, 10, 0, 4, 32'h1000, 32'h55, 32'h8, 1, 3'b000, 1, 1);
        check_stall("stall_lw", 0);
        push_exp(3'b000, 32'h1000, 32'h8, 32'h55, 4, 1, 1);
        tick();

        // dependent AND on rs2=4: load-use stall
        set_fwd(0, 0, 0, 0, 0, 0);
        set_id(1, 11, 4, 12, 32'd1, 32'd2, 0, 0, 3'b010, 1, 0);
        check("lw_in_ex_memread", {31'd0, ex_memread}, 1);
        check_stall("stall_load_use", 1);
        tick();
        check_bubble("load_use_bubble");
        set_fwd(4, 1, 32'h77, 0, 0, 0);
`ifdef FORWARDING_EN
        check_stall("stall_after_bubble", 0);
        push_exp(3'b010, 32'd1, 32'h77, 32'h77, 12, 1, 0);
        tick();
        set_fwd(0, 0, 0, 4, 1, 32'h77);
`else
        check_stall("stall_raw_mem", 1);
        tick();
        check_bubble("raw_mem_bubble");
        set_fwd(0, 0, 0, 4, 1, 32'h77);
        check_stall("stall_after_wb", 0);
        push_exp(3'b010, 32'd1, 32'd2, 32'd2, 12, 1, 0);
        tick();
        set_fwd(0, 0, 0, 0, 0, 0);
`endif

        // flush alone squashes the ID instruction
        set_id(1, 13, 14, 15, 32'h1, 32'h2, 0, 0, 3'b011, 1, 0);
        flush = 1'b1;
        check_stall("stall_flush", 0);
        tick();
        flush = 1'b0;
        set_fwd(0, 0, 0, 0, 0, 0);
        check_bubble("flush_bubble");
        check("flush_ex_rd", {27'd0, ex_rd}, 0);
        check("flush_aluctrl", {29'd0, ALUctrl}, 0);

        // flush together with a load-use hazard
        set_id(1, 1, 0, 4, 32'h2000, 0, 32'h4, 1, 3'b000, 1, 1);
        check_stall("stall_lw2", 0);
        push_exp(3'b000, 32'h2000, 32'h4, 0, 4, 1, 1);
        tick();
        set_id(1, 4, 0, 6, 32'h3, 0, 0, 0, 3'b000, 1, 0);
        flush = 1'b1;
        check_stall("stall_flush_hz", 0);
        tick();
        flush = 1'b0;
        check_bubble("flush_hz_bubble");

        // SUB rd=2 followed by a reader of x2
        set_id(1, 1, 0, 2, 32'd9, 32'd3, 0, 0, 3'b001, 1, 0);
        check_stall("stall_sub2", 0);
        push_exp(3'b001, 32'd9, 32'd3, 32'd3, 2, 1, 0);
        tick();
        set_id(1, 2, 0, 5, 32'd6, 0, 32'h20, 1, 3'b101, 1, 0);
`ifdef FORWARDING_EN
        check_stall("stall_raw_fwd", 0);
        push_exp(3'b101, 32'h99, 32'h20, 0, 5, 1, 0);
        tick();
        set_fwd(2, 1, 32'h99, 0, 0, 0);
`else
        check_stall("stall_raw_ex", 1);
        tick();
        set_fwd(2, 1, 0, 0, 0, 0);
        check_bubble("raw_ex_bubble");
        check_stall("stall_raw_mem2", 1);
        tick();
        set_fwd(0, 0, 0, 2, 1, 0);
        check_stall("stall_raw_wb", 0);
        push_exp(3'b101, 32'd6, 32'h20, 0, 5, 1, 0);
        tick();
`endif
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0);
        check("pre_reset_ex_valid", {31'd0, ex_valid}, 1);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check_zero("midrun_reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        set_fwd(0, 0, 0, 0, 0, 0);
        repeat (3) tick();
        check("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
